// File: rtl/score_bcd_counter.sv
// Three-digit BCD score accumulator: button edges become serial +1/-1 steps with saturation at MAX_SCORE.
// Optional single-level undo (btn_undo, last_delta) is compiled in when SCORE_UNDO_EN is defined.
module score_bcd_counter #(
    parameter int MAX_SCORE = 199
) (
    input  logic       clk,
    input  logic       nRst,
`ifdef SCORE_UNDO_EN
    input  logic       btn_undo,
`endif
    input  logic       btn_add1,
    input  logic       btn_add2,
    input  logic       btn_add3,
    input  logic       btn_sub1,
    input  logic       btn_clr,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic       busy,
    output logic       sat
);

    typedef enum logic [1:0] {S_IDLE, S_INC, S_DEC} state_t;

    localparam logic [3:0] MAX_H = 4'(MAX_SCORE / 100);
    localparam logic [3:0] MAX_T = 4'((MAX_SCORE / 10) % 10);
    localparam logic [3:0] MAX_U = 4'(MAX_SCORE % 10);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_hun, r_ten, r_uni;
    logic [3:0] w_hun_nxt, w_ten_nxt, w_uni_nxt;
    logic [3:0] w_inc_hun, w_inc_ten, w_inc_uni;
    logic [3:0] w_dec_hun, w_dec_ten, w_dec_uni;
    logic [1:0] r_pend, w_pend_nxt;
    logic       r_sat, w_sat_nxt;
    logic [4:0] r_prev;
    logic [4:0] w_btn, w_cmd;
    logic       w_at_max, w_at_zero;

`ifdef SCORE_UNDO_EN
    logic              r_prev_undo;
    logic              w_cmd_undo;
    logic signed [2:0] r_last_delta, w_last_nxt;
    logic [1:0]        r_applied, w_applied_nxt;
    logic              r_undo_seq, w_undo_seq_nxt;

    assign w_cmd_undo = btn_undo & ~r_prev_undo;
`endif

    // bit order: {clr, sub1, add3, add2, add1}
    assign w_btn     = {btn_clr, btn_sub1, btn_add3, btn_add2, btn_add1};
    assign w_cmd     = w_btn & ~r_prev;
    assign w_at_max  = (r_hun == MAX_H) && (r_ten == MAX_T) && (r_uni == MAX_U);
    assign w_at_zero = (r_hun == 4'd0) && (r_ten == 4'd0) && (r_uni == 4'd0);

    always_comb begin
        w_inc_hun = r_hun;
        w_inc_ten = r_ten;
        w_inc_uni = r_uni + 4'd1;
        if (r_uni == 4'd9) begin
            w_inc_uni = 4'd0;
            w_inc_ten = r_ten + 4'd1;
            if (r_ten == 4'd9) begin
                w_inc_ten = 4'd0;
                w_inc_hun = r_hun + 4'd1;
            end
        end
    end

    always_comb begin
        w_dec_hun = r_hun;
        w_dec_ten = r_ten;
        w_dec_uni = r_uni - 4'd1;
        if (r_uni == 4'd0) begin
            w_dec_uni = 4'd9;
            w_dec_ten = r_ten - 4'd1;
            if (r_ten == 4'd0) begin
                w_dec_ten = 4'd9;
                w_dec_hun = r_hun - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hun_nxt   = r_hun;
        w_ten_nxt   = r_ten;
        w_uni_nxt   = r_uni;
        w_pend_nxt  = r_pend;
        w_sat_nxt   = 1'b0;
`ifdef SCORE_UNDO_EN
        w_last_nxt     = r_last_delta;
        w_applied_nxt  = r_applied;
        w_undo_seq_nxt = r_undo_seq;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef SCORE_UNDO_EN
                w_applied_nxt  = 2'd0;
                w_undo_seq_nxt = 1'b0;
`endif
                if (w_cmd[4]) begin
                    w_hun_nxt = 4'd0;
                    w_ten_nxt = 4'd0;
                    w_uni_nxt = 4'd0;
`ifdef SCORE_UNDO_EN
                    w_last_nxt = 3'sd0;
                end else if (w_cmd_undo) begin
                    w_last_nxt     = 3'sd0;
                    w_undo_seq_nxt = 1'b1;
                    if (r_last_delta > 3'sd0) begin
                        w_pend_nxt  = r_last_delta[1:0];
                        w_state_nxt = S_DEC;
                    end else if (r_last_delta == -3'sd1) begin
                        w_pend_nxt  = 2'd1;
                        w_state_nxt = S_INC;
                    end
`endif
                end else if (w_cmd[3]) begin
                    w_pend_nxt  = 2'd1;
                    w_state_nxt = S_DEC;
                end else if (w_cmd[2]) begin
                    w_pend_nxt  = 2'd3;
                    w_state_nxt = S_INC;
                end else if (w_cmd[1]) begin
                    w_pend_nxt  = 2'd2;
                    w_state_nxt = S_INC;
                end else if (w_cmd[0]) begin
                    w_pend_nxt  = 2'd1;
                    w_state_nxt = S_INC;
                end
            end
            S_INC: begin
                if (w_at_max) begin
                    w_sat_nxt   = 1'b1;
                    w_pend_nxt  = 2'd0;
                    w_state_nxt = S_IDLE;
`ifdef SCORE_UNDO_EN
                    if (!r_undo_seq) w_last_nxt = {1'b0, r_applied};
`endif
                end else begin
                    w_hun_nxt  = w_inc_hun;
                    w_ten_nxt  = w_inc_ten;
                    w_uni_nxt  = w_inc_uni;
                    w_pend_nxt = r_pend - 2'd1;
`ifdef SCORE_UNDO_EN
                    w_applied_nxt = r_applied + 2'd1;
                    if (r_pend == 2'd1 && !r_undo_seq) w_last_nxt = {1'b0, 2'(r_applied + 2'd1)};
`endif
                    if (r_pend == 2'd1) w_state_nxt = S_IDLE;
                end
            end
            S_DEC: begin
                if (!w_at_zero) begin
                    w_hun_nxt = w_dec_hun;
                    w_ten_nxt = w_dec_ten;
                    w_uni_nxt = w_dec_uni;
                end
                w_pend_nxt = r_pend - 2'd1;
                if (r_pend == 2'd1) begin
                    w_state_nxt = S_IDLE;
`ifdef SCORE_UNDO_EN
                    if (!r_undo_seq) w_last_nxt = w_at_zero ? 3'sd0 : -3'sd1;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // history resets high so a button held through reset release is not seen as a press
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
            r_hun   <= 4'd0;
            r_ten   <= 4'd0;
            r_uni   <= 4'd0;
            r_pend  <= 2'd0;
            r_sat   <= 1'b0;
            r_prev  <= 5'b11111;
`ifdef SCORE_UNDO_EN
            r_prev_undo  <= 1'b1;
            r_last_delta <= 3'sd0;
            r_applied    <= 2'd0;
            r_undo_seq   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_hun   <= w_hun_nxt;
            r_ten   <= w_ten_nxt;
            r_uni   <= w_uni_nxt;
            r_pend  <= w_pend_nxt;
            r_sat   <= w_sat_nxt;
            r_prev  <= w_btn;
`ifdef SCORE_UNDO_EN
            r_prev_undo  <= btn_undo;
            r_last_delta <= w_last_nxt;
            r_applied    <= w_applied_nxt;
            r_undo_seq   <= w_undo_seq_nxt;
`endif
        end
    end

    assign bcd_hundreds = r_hun;
    assign bcd_tens     = r_ten;
    assign bcd_units    = r_uni;
    assign busy         = (r_state != S_IDLE);
    assign sat          = r_sat;

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Per-team basketball score accumulator for the scoreboard.
- Converts operator button events (+1, +2, +3, -1, clear) into a three-digit BCD score.
- Each digit output drives one 7-segment decoder instance directly downstream.
- Multi-point additions are applied serially, one point per clock, through a small FSM, so carry and saturation are handled uniformly.

Parameters:
MAX_SCORE, 199, saturation ceiling in decimal (legal range 1..999); the score never exceeds it.

Ports:
clk  input  1  system clock, rising-edge active
nRst  input  1  asynchronous active-low reset
btn_add1  input  1  level button, already synchronized/debounced; each rising edge = +1 command
btn_add2  input  1  as above, +2
btn_add3  input  1  as above, +3
btn_sub1  input  1  as above, -1 correction
btn_clr  input  1  as above, score to zero
bcd_hundreds  output  4  hundreds digit, always 0..9
bcd_tens  output  4  tens digit, always 0..9
bcd_units  output  4  units digit, always 0..9
busy  output  1  high while a serial INC/DEC sequence is in progress
sat  output  1  one-cycle pulse when an increment is refused at MAX_SCORE

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (nRst); all state is cleared immediately when it asserts.
- Reset values:
  - Digits 000, busy 0, sat 0.
  - FSM in IDLE, pending count 0.
  - Edge-detect history registers reset to 1, so a button held through reset release does not fire.
- Edge detection: cmd_x = btn_x & ~prev_x; prev_x <= btn_x every cycle.
- Command priority when several edges occur in one cycle: clr > sub1 > add3 > add2 > add1. Only the highest-priority command is taken.
- Edges that arrive while the FSM is not in IDLE are dropped. They are not queued.
- FSM states: IDLE, INC, DEC.
- IDLE, at the edge k where a command is detected:
  - clr: digits set to 000 at edge k; FSM stays in IDLE; busy stays 0.
  - addN: pending <= N; go to INC; busy = 1 from edge k.
  - sub1: pending <= 1; go to DEC; busy = 1 from edge k.
- INC, one step per edge:
  - If score == MAX_SCORE: no change, sat = 1 for exactly one cycle, pending <= 0, go to IDLE.
  - Otherwise score += 1 with BCD carry (units 9->0 carries to tens; tens 9->0 carries to hundreds), pending -= 1.
  - When pending reaches 0, go to IDLE.
- DEC, one step per edge:
  - If score == 000: no change (floor, no flag).
  - Otherwise score -= 1 with BCD borrow (units 0->9 borrows from tens, and so on).
  - pending -= 1; when pending reaches 0, go to IDLE.
- Latency:
  - addN with no saturation: final score visible after edge k+N; busy high for exactly N cycles.
  - sub1: busy high for 1 cycle.
- busy is a registered output: busy = (state != IDLE).
- Outputs never hold a non-BCD code, in any state or transition.
- Reset asserted mid-sequence: the score and pending count are discarded immediately, with no partial completion.

Optional Feature:
- Macro: SCORE_UNDO_EN.
- When defined:
  - Adds input port btn_undo (1 bit, edge-detected like the other buttons). Priority: clr > undo > sub1 > add3 > add2 > add1.
  - A signed register last_delta records the points actually applied by the last completed command: +applied for addN, counting only successful increments; -1 for a sub1 that changed the score; 0 after clr, reset or undo.
  - On an undo edge in IDLE:
    - last_delta > 0: enter DEC with pending = last_delta.
    - last_delta = -1: enter INC with pending = 1; the saturation rule still applies.
    - last_delta = 0: no action.
  - last_delta is then set to 0. Undo is single-level only.
- When not defined: no btn_undo port and no last_delta storage; behaviour is exactly as above.

Test Plan:
- Reset/hold: nRst low with btn_add1 held high, then release -> digits 000, busy 0, no increment; then release and re-press btn_add1 -> 001 after 1 cycle.
- Carry: score 098, btn_add3 edge -> busy high for 3 cycles; score 099, 100, 101 on successive edges; final 1/0/1.
- Saturation: MAX_SCORE=199, score 198, btn_add3 -> 199 after 1 step; sat pulse on next edge; busy high 2 cycles total; score stays 199.
- Floor/priority: score 000, btn_sub1 and btn_add2 rise in the same cycle -> sub1 wins; score stays 000; busy high 1 cycle.
- Drop while busy: btn_add3 at 010, btn_add1 edge 1 cycle later -> final 013, not 014; btn_clr afterwards -> 000 in 1 cycle, busy stays 0.
- Async reset mid-INC: 050 + add3, nRst low after 1 step -> immediate 000, busy 0. With SCORE_UNDO_EN: 197 + add3 (saturates at 199, last_delta=+2), undo -> 197 after 2 cycles; second undo -> no change.
